// File: rtl/seg_scroll_ctrl.sv
// Seven-segment scrolling display controller: a 64-entry character buffer shown
// on NDIG multiplexed digits, either statically or as a rotating marquee.
module seg_scroll_ctrl #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int SCROLL_DIV  = 12_500_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_valid,
    input  logic [6:0]      wr_data,
    output logic            wr_ready,
    input  logic            clear,
    input  logic            scroll_en,
    output logic [6:0]      seg,
    output logic [NDIG-1:0] an,
    output logic [6:0]      count
);

    localparam int DEPTH = 64;
    localparam int RW    = $clog2(REFRESH_DIV);
    localparam int SW    = $clog2(SCROLL_DIV);
    localparam int DW    = $clog2(NDIG);

    typedef enum logic [1:0] {
        MODE_EMPTY,
        MODE_STATIC,
        MODE_SCROLL
    } mode_t;

    mode_t          mode_q, mode_d;
    logic [6:0]     count_d;
    logic [5:0]     pos_q, pos_d;
    logic [SW-1:0]  tmr_q, tmr_d;
    logic [RW-1:0]  rf_q;
    logic [DW-1:0]  dig_q;
    logic           wr_accept;
    logic [6:0]     sum;
    logic [5:0]     idx;
    logic [6:0]     seg_d;
    logic [NDIG-1:0] an_d;
    logic [6:0]     mem [DEPTH];

    assign wr_ready  = (count < 7'(DEPTH)) && !clear;
    assign wr_accept = wr_valid && wr_ready;

    // Next count, scroll position and scroll timer; mode follows the new count.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count;
        pos_d   = pos_q;
        tmr_d   = tmr_q;
        if (clear) begin
            count_d = '0;
            pos_d   = '0;
            tmr_d   = '0;
        end else begin
            if (wr_accept) count_d = count + 7'd1;
            if (mode_q != MODE_SCROLL) begin
                pos_d = '0;
                tmr_d = '0;
            end else if (scroll_en) begin
                if (tmr_q == SW'(SCROLL_DIV - 1)) begin
                    tmr_d = '0;
                    pos_d = (7'(pos_q) == count - 7'd1) ? 6'd0 : pos_q + 6'd1;
                end else begin
                    tmr_d = tmr_q + SW'(1);
                end
            end
        end

        if (count_d == 7'd0)             mode_d = MODE_EMPTY;
        else if (count_d <= 7'(NDIG))    mode_d = MODE_STATIC;
        else                             mode_d = MODE_SCROLL;
    end

    // Digit contents; in scroll mode pos + dig < 2*count, so one subtract is a full modulo.
    always_comb begin
        sum   = 7'(pos_q) + 7'(dig_q);
        idx   = 6'((sum >= count) ? sum - count : sum);
        seg_d = 7'b0000000;
        case (mode_q)
            MODE_STATIC: seg_d = (7'(dig_q) < count) ? mem[6'(dig_q)] : 7'b0000000;
            MODE_SCROLL: seg_d = mem[idx];
            default:     seg_d = 7'b0000000;
        endcase
        an_d = ~(NDIG'(1) << dig_q);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_EMPTY;
            count  <= '0;
            pos_q  <= '0;
            tmr_q  <= '0;
            rf_q   <= '0;
            dig_q  <= '0;
            seg    <= 7'b0000000;
            an     <= ~NDIG'(1);
        end else begin
            mode_q <= mode_d;
            count  <= count_d;
            pos_q  <= pos_d;
            tmr_q  <= tmr_d;
            if (rf_q == RW'(REFRESH_DIV - 1)) begin
                rf_q  <= '0;
                dig_q <= (dig_q == DW'(NDIG - 1)) ? '0 : dig_q + DW'(1);
            end else begin
                rf_q <= rf_q + RW'(1);
            end
            seg <= seg_d;
            an  <= an_d;
        end
    end

    // NOTE: the buffer is deliberately not reset; entries at or beyond count are never displayed.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) mem[count[5:0]] <= wr_data;
    end

endmodule
